sc_rr_crossbar_nxm: RTL
=======================

# sc_rr_crossbar_nxm

Parametrised N-master × M-slave crossbar with an independent round-robin arbiter per slave, registered grants held for a whole transaction, address-based slave decode, a decode-error responder and a per-slave watchdog timeout. It replaces the fixed 2×2 crossbar wherever more masters or slaves share the single-cycle req/ack bus. All per-channel buses are flattened: channel k occupies bits [k*W +: W].

## Interface
- N_MASTERS, 4: number of masters (≥1).
- N_SLAVES, 4: number of slaves (≥1).
- AW, 32: address width.
- DW, 32: data width.
- SW, clog2(N_SLAVES) (min 1): slave-select width; select = addr[AW-1 -: SW].
- TIMEOUT, 256: cycles a granted slave may take to ack; 0 disables the watchdog.
- i_clk  in  1  clock.
- i_resetb  in  1  reset; one clock; reset is asynchronous and active-low.
- i_m_req  in  N_MASTERS  request, held until ack.
- i_m_addr  in  N_MASTERS*AW  address.
- i_m_cmd  in  N_MASTERS  1 = write, 0 = read.
- i_m_wdata  in  N_MASTERS*DW  write data.
- o_m_ack  out  N_MASTERS  one-cycle completion pulse.
- o_m_err  out  N_MASTERS  qualifies o_m_ack: decode error or timeout.
- o_m_rdata  out  N_MASTERS*DW  read data, valid with o_m_ack.
- o_m_wait  out  N_MASTERS  req high, no grant, no error pending.
- o_s_req / o_s_addr / o_s_cmd / o_s_wdata  out  N_SLAVES / N_SLAVES*AW / N_SLAVES / N_SLAVES*DW  slave request bus.
- i_s_ack  in  N_SLAVES  slave one-cycle ack.
- i_s_rdata  in  N_SLAVES*DW  slave read data, valid with ack.
- o_s_busy  out  N_SLAVES  slave FSM in BUSY.

## Operation
- Decode: sel = addr[AW-1 -: SW]. sel ≥ N_SLAVES means decode error.
- Per-slave FSM, states IDLE and BUSY.
- IDLE: the candidates are masters with req=1 and a valid sel equal to this slave. The slave picks the first candidate searching from ptr+1 upward, modulo N_MASTERS.
  - A pick registers grant[idx] and moves the FSM to BUSY.
  - No candidates: stay in IDLE.
- BUSY: the granted master's req/addr/cmd/wdata are routed combinationally to the slave. Non-granted masters see no ack.
  - i_s_ack=1: route ack and rdata to the granted master in the same cycle, with err=0. Then set ptr←idx and go to IDLE.
  - Watchdog: counter cleared on entering BUSY and incremented each BUSY cycle. When TIMEOUT≠0 and count = TIMEOUT-1 with no ack, pulse o_m_ack=1, o_m_err=1, rdata=0 to the granted master. Drop o_s_req that cycle, set ptr←idx and go to IDLE.
  - Ack and timeout in the same cycle: ack wins, err=0.
  - A late slave ack while in IDLE is ignored and not routed.
- A master whose req falls while granted still holds the grant until ack or timeout. o_s_req follows the master's req, gated by the grant.
- Decode-error responder, per master: err_q ← req & bad_sel & ~err_q. While err_q=1, drive o_m_ack=1, o_m_err=1, rdata=0. A request held high re-errors every second cycle.
- Idle outputs are zero:
  - o_s_addr, o_s_cmd and o_s_wdata are 0 when the slave FSM is IDLE.
  - o_m_rdata is 0 when o_m_ack=0.
- Per-master ack is the OR over slaves plus the error path. At most one source is active at a time by construction.
- Reset, async and active-low:
  - FSMs go to IDLE, grants clear, counters go to 0, err_q goes to 0.
  - ptr = N_MASTERS-1, so master 0 wins first.
  - All outputs are 0 immediately, including mid-transaction.

## Timing
- Master req at cycle 0, slave IDLE: o_s_req=1 from cycle 1. With slave ack in cycle k, o_m_ack=1 in cycle k (combinational path).
- After ack in cycle k, the FSM is IDLE in cycle k+1 and may grant again for cycle k+2. Minimum 2 cycles per transaction per slave; different slaves run concurrently.
- Decode error: req at cycle 0 gives ack+err in cycle 1.
- Timeout: grant at edge 1 gives ack+err in cycle TIMEOUT, and o_s_req=0 in that cycle.
- Fairness: a continuously requesting master is granted within N_MASTERS transactions of a slave.

## Test plan
- Reset, then M0 reads slave 2 (addr 0x8000_0010, N=M=4), slave acks 1 cycle after o_s_req with rdata 0xA5A5_0001 -> o_s_req[2] in cycle 1, M0 gets ack+rdata 0xA5A5_0001 in cycle 2, err=0.
- M0..M3 all hold req to slave 0, slave acks every cycle req is high -> grant order 0,1,2,3,0; each transaction takes 2 cycles; o_m_wait high for the waiting masters.
- M0→slave 1 and M1→slave 3 simultaneously -> both o_s_req high in cycle 1, independent acks routed to the correct masters, no cross-talk on rdata.
- N_SLAVES=3, M2 addr 0xC000_0000 -> o_m_ack[2]=o_m_err[2]=1 in cycle 1; no o_s_req asserted.
- TIMEOUT=8, slave 1 never acks -> ack+err with rdata 0 in cycle 8, o_s_busy[1]=0 the next cycle. A late i_s_ack[1] in cycle 10 produces no master ack.
- Assert i_resetb=0 mid-BUSY -> all o_s_req and o_m_ack drop immediately. After release, master 0 wins the first contention.

Source files
------------

// File: rtl/sc_rr_crossbar_nxm.sv
// N-master x M-slave crossbar: address-decoded, one round-robin arbiter per slave with
// grants held for a whole transaction, a decode-error responder and a per-slave watchdog.
module sc_rr_crossbar_nxm #(
    parameter int N_MASTERS = 4,
    parameter int N_SLAVES  = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int SW        = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
    parameter int TIMEOUT   = 256
) (
    input  logic                    i_clk,
    input  logic                    i_resetb,
    input  logic [N_MASTERS-1:0]    i_m_req,
    input  logic [N_MASTERS*AW-1:0] i_m_addr,
    input  logic [N_MASTERS-1:0]    i_m_cmd,
    input  logic [N_MASTERS*DW-1:0] i_m_wdata,
    output logic [N_MASTERS-1:0]    o_m_ack,
    output logic [N_MASTERS-1:0]    o_m_err,
    output logic [N_MASTERS*DW-1:0] o_m_rdata,
    output logic [N_MASTERS-1:0]    o_m_wait,
    output logic [N_SLAVES-1:0]     o_s_req,
    output logic [N_SLAVES*AW-1:0]  o_s_addr,
    output logic [N_SLAVES-1:0]     o_s_cmd,
    output logic [N_SLAVES*DW-1:0]  o_s_wdata,
    input  logic [N_SLAVES-1:0]     i_s_ack,
    input  logic [N_SLAVES*DW-1:0]  i_s_rdata,
    output logic [N_SLAVES-1:0]     o_s_busy
);
    // Handshake: a master holds req (with stable addr/cmd/wdata) until it sees a one-cycle
    // ack; err qualifies that same ack. Slaves see req only while granted and answer with ack.
    localparam int MIW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [SW:0]   NS_LIM  = (SW+1)'(N_SLAVES);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    logic [N_MASTERS-1:0][SW-1:0]       m_sel;
    logic [N_MASTERS-1:0]               bad_sel;
    logic [N_MASTERS-1:0]               err_q;
    logic [N_MASTERS-1:0]               m_granted;
    logic [N_SLAVES-1:0][N_MASTERS-1:0] s2m_ack, s2m_err, s2m_gnt;
    logic [N_SLAVES-1:0][DW-1:0]        s2m_rdata;

    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            m_sel[m]   = i_m_addr[m*AW + AW - 1 -: SW];
            bad_sel[m] = {1'b0, m_sel[m]} >= NS_LIM;
        end
    end

    // Self-clearing so a held bad request answers every second cycle.
    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) err_q <= '0;
        else           err_q <= i_m_req & bad_sel & ~err_q;
    end

    for (genvar s = 0; s < N_SLAVES; s++) begin : g_slv
        state_t               state_q, state_d;
        logic [MIW-1:0]       gnt_q, gnt_d, ptr_q, ptr_d, pick_idx;
        logic [CW-1:0]        cnt_q, cnt_d;
        logic                 pick_vld, busy, ack, tmo;
        logic [N_MASTERS-1:0] gnt_oh;
        int                   cand;

        // First requesting candidate searching upward from ptr+1, wrapping.
        always_comb begin
            pick_vld = 1'b0;
            pick_idx = '0;
            cand     = 0;
            for (int k = 1; k <= N_MASTERS; k++) begin
                cand = (int'(ptr_q) + k) % N_MASTERS;
                if (!pick_vld && i_m_req[cand] && !bad_sel[cand] && (m_sel[cand] == SW'(s))) begin
                    pick_vld = 1'b1;
                    pick_idx = MIW'(cand);
                end
            end
        end

        assign busy = (state_q == S_BUSY);
        assign ack  = busy & i_s_ack[s];
        assign tmo  = (TIMEOUT != 0) && busy && !i_s_ack[s] && (cnt_q == TO_LAST);

        always_comb begin
            state_d = state_q;
            gnt_d   = gnt_q;
            ptr_d   = ptr_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_d = S_BUSY;
                        gnt_d   = pick_idx;
                        cnt_d   = '0;
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (ack || tmo) begin
                        state_d = S_IDLE;
                        ptr_d   = gnt_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        always_ff @(posedge i_clk or negedge i_resetb) begin
            if (!i_resetb) begin
                state_q <= S_IDLE;
                gnt_q   <= '0;
                ptr_q   <= MIW'(N_MASTERS - 1);
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                gnt_q   <= gnt_d;
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
            end
        end

        assign o_s_busy[s]           = busy;
        assign o_s_req[s]            = busy & i_m_req[gnt_q] & ~tmo;
        assign o_s_addr[s*AW +: AW]  = busy ? i_m_addr[int'(gnt_q)*AW +: AW] : '0;
        assign o_s_cmd[s]            = busy & i_m_cmd[gnt_q];
        assign o_s_wdata[s*DW +: DW] = busy ? i_m_wdata[int'(gnt_q)*DW +: DW] : '0;

        assign gnt_oh       = busy ? (N_MASTERS'(1) << gnt_q) : '0;
        assign s2m_gnt[s]   = gnt_oh;
        assign s2m_ack[s]   = (ack | tmo) ? gnt_oh : '0;
        assign s2m_err[s]   = tmo ? gnt_oh : '0;
        assign s2m_rdata[s] = ack ? i_s_rdata[s*DW +: DW] : '0;
    end

    // A master is granted by at most one slave, so plain ORs merge the response paths.
    always_comb begin
        o_m_ack   = err_q;
        o_m_err   = err_q;
        o_m_rdata = '0;
        m_granted = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            o_m_ack   = o_m_ack | s2m_ack[s];
            o_m_err   = o_m_err | s2m_err[s];
            m_granted = m_granted | s2m_gnt[s];
            for (int m = 0; m < N_MASTERS; m++) begin
                if (s2m_ack[s][m]) o_m_rdata[m*DW +: DW] = o_m_rdata[m*DW +: DW] | s2m_rdata[s];
            end
        end
    end

    assign o_m_wait = {N_MASTERS{i_resetb}} & i_m_req & ~m_granted & ~err_q;

endmodule
